// File: rtl/shift_pkg.sv
// Shared definitions for the 32-bit shift unit: widths, one-hot op codes and the
// bit-reversal helper used to build the left shift from the right shifter.
package shift_pkg;

    localparam int unsigned SHIFT_W = 32;
    localparam int unsigned SHAMT_W = 5;

    // One-hot {sll, srl, sra} encoding for decoders and benches
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b001;

    function automatic logic [SHIFT_W-1:0] bitrev32(input logic [SHIFT_W-1:0] value);
        logic [SHIFT_W-1:0] rev;
        rev = '0;
        for (int i = 0; i < int'(SHIFT_W); i++) begin
            rev[i] = value[SHIFT_W-1-i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/shift32_stage.sv
// One log stage of the right barrel shifter: shifts right by DIST when enabled,
// filling the vacated top bits with the supplied fill bit.
module shift32_stage
    import shift_pkg::*;
#(
    parameter int unsigned DIST = 1
) (
    input  logic               en,
    input  logic               fill,
    input  logic [SHIFT_W-1:0] in,
    output logic [SHIFT_W-1:0] out
);

    // Bits shifted off the bottom are intentionally discarded
    logic unused_low;
    assign unused_low = ^in[DIST-1:0];

    assign out = en ? {{DIST{fill}}, in[SHIFT_W-1:DIST]} : in;

endmodule

// File: rtl/shift32.sv
// Combinational 32-bit barrel shifter (sll/srl/sra). Left shifts reuse the right
// shifter on a bit-reversed operand; clock and reset exist for interface uniformity.
module shift32
    import shift_pkg::*;
(
    input  logic               m_clock,
    input  logic               p_reset,
    input  logic               sll,
    input  logic               srl,
    input  logic               sra,
    input  logic [SHIFT_W-1:0] in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [SHIFT_W-1:0] out
);

    logic unused_ctl;
    assign unused_ctl = m_clock ^ p_reset;

    // Strobe priority sll > srl > sra; no strobe leaves every stage disabled
    logic sll_sel;
    logic srl_sel;
    logic sra_sel;
    logic any_sel;

    assign sll_sel = sll;
    assign srl_sel = ~sll & srl;
    assign sra_sel = ~sll & ~srl & sra;
    assign any_sel = sll_sel | srl_sel | sra_sel;

    logic                            fill;
    logic [SHAMT_W:0][SHIFT_W-1:0]   stage;

    assign fill     = sra_sel & in[SHIFT_W-1];
    assign stage[0] = sll_sel ? bitrev32(in) : in;

    for (genvar i = 0; i < int'(SHAMT_W); i++) begin : g_stage
        shift32_stage #(
            .DIST (32'(1) << i)
        ) u_stage (
            .en   (shamt[i] & any_sel),
            .fill (fill),
            .in   (stage[i]),
            .out  (stage[i+1])
        );
    end

    assign out = sll_sel ? bitrev32(stage[SHAMT_W]) : stage[SHAMT_W];

endmodule

// File: tb/tb_shift32.sv
// Self-checking bench for shift32: directed corner vectors plus random vectors
// compared against a behavioural shift model.
module tb_shift32;
    import shift_pkg::*;

    logic               m_clock;
    logic               p_reset;
    logic               sll;
    logic               srl;
    logic               sra;
    logic [SHIFT_W-1:0] d_in;
    logic [SHAMT_W-1:0] shamt;
    logic [SHIFT_W-1:0] d_out;

    int total = 0;
    int bad   = 0;

    shift32 dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .sll     (sll),
        .srl     (srl),
        .sra     (sra),
        .in      (d_in),
        .shamt   (shamt),
        .out     (d_out)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    // Reference: shift operators applied with the strobe priority rules
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [4:0] sh);
        if (op[2])      return a << sh;
        else if (op[1]) return a >> sh;
        else if (op[0]) return 32'($signed(a) >>> sh);
        else            return a;
    endfunction

    task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [4:0] sh,
                         input logic [31:0] expected, input string tag);
        @(posedge m_clock);
        {sll, srl, sra} = op;
        d_in  = a;
        shamt = sh;
        @(negedge m_clock);
        total++;
        assert (d_out === expected) else begin
            bad++;
            $error("FAIL %s: op=%b in=%h shamt=%0d out=%h expected=%h",
                   tag, op, a, sh, d_out, expected);
        end
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_in;
        logic [4:0]  r_sh;

        p_reset = 1'b1;
        {sll, srl, sra} = 3'b000;
        d_in  = 32'h1234_5678;
        shamt = 5'd3;
        apply(3'b000, 32'h1234_5678, 5'd3, 32'h1234_5678, "reset_passthru");
        p_reset = 1'b0;

        apply(OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll_31");
        apply(OP_SLL, 32'h0000_0001, 5'd4,  32'h0000_0010, "sll_4");
        apply(OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, "srl_31");
        apply(OP_SRL, 32'hF0F0_F0F0, 5'd4,  32'h0F0F_0F0F, "srl_4");
        apply(OP_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, "sra_4");
        apply(OP_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, "sra_31_pos");
        apply(OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "sra_31_neg");
        apply(OP_SLL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "sll_0");
        apply(OP_SRL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "srl_0");
        apply(OP_SRA, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "sra_0");
        apply(3'b000, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, "none_7");
        apply(3'b111, 32'h8000_0001, 5'd1,  32'h0000_0002, "prio_all");
        apply(3'b011, 32'h8000_0001, 5'd1,  32'h4000_0000, "prio_srl_sra");
        apply(3'b101, 32'h8000_0001, 5'd1,  32'h0000_0002, "prio_sll_sra");
        apply(OP_SRA, 32'h8000_0001, 5'd1,  32'hC000_0000, "sra_1");

        p_reset = 1'b1;
        apply(OP_SRA, 32'hFFFF_0000, 5'd16, 32'hFFFF_FFFF, "sra_in_reset");
        p_reset = 1'b0;
        apply(OP_SRA, 32'hFFFF_0000, 5'd16, 32'hFFFF_FFFF, "sra_after_reset");

        for (int i = 0; i < 128; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_in = $urandom;
            r_sh = 5'($urandom_range(0, 31));
            apply(r_op, r_in, r_sh, model(r_op, r_in, r_sh), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
